deal_scheduler: RTL and testbench
=================================

DEAL_SCHEDULER -- requirements
Module: deal_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk, input, 1, rising-edge clock; reset, input, 1, asynchronous active-high reset.
REQ-002 The block SHALL have these Avalon-MM slave ports: address (input, 2, register select); chipselect (input, 1); write_n (input, 1, active-low write); writedata (input, 32); readdata (output, 32, combinational read mux).
REQ-003 The block SHALL have these requester ports: req_player (input, 1) and req_dealer (input, 1), each a level-held hit request.
REQ-004 The block SHALL have these grant ports: gnt_player (output, 1) and gnt_dealer (output, 1), each a one-cycle pulse per dealt card.
REQ-005 The block SHALL have these card output ports: player_card (output, 8) and dealer_card (output, 8), each driving a card PIO; bit7 is valid and bits[5:0] hold card 1..52.
REQ-006 The block SHALL have a status output: shoe_empty (output, 1), high when 52 cards have been dealt.

Function
REQ-007 The register map SHALL be:
- 0 CTRL (W): bit0 clear_shoe self-clearing; bit1 enable.
- 1 STATUS (R): bit0 busy; bit1 shoe_empty; bits[13:8] cards_dealt.
- 2 SEED (W/R): bits[5:0]; see Configuration.
- 3: reads 0, writes ignored.
REQ-008 Writes SHALL occur when chipselect && !write_n; readdata SHALL be zero-extended and combinational on address.
REQ-009 The FSM SHALL have states IDLE, DRAW, CHECK, WRITE.
REQ-010 In IDLE, the FSM SHALL go to DRAW when enable=1, shoe_empty=0 and at least one request is high, latching the winner.
REQ-011 When both requests are high, the winner SHALL be the side not served last; last-served resets to dealer, so the player wins the first tie.
REQ-012 In DRAW, the FSM SHALL step a 6-bit Fibonacci LFSR (next = {lfsr[4:0], lfsr[5]^lfsr[4]}) once and go to CHECK.
REQ-013 In CHECK, if lfsr>52 or dealt_mask[lfsr-1]=1, the FSM SHALL return to DRAW; otherwise it SHALL go to WRITE.
REQ-014 In WRITE, the FSM SHALL set the mask bit, increment cards_dealt, load {1'b1,1'b0,lfsr} into the winner's card register, pulse the winner's gnt, update last-served and return to IDLE.
REQ-015 The card register update and the gnt pulse SHALL occur on the same edge; minimum latency SHALL be 4 edges from the IDLE sample to gnt.
REQ-016 A maximal-length LFSR SHALL guarantee any undealt card is found within 63 DRAW/CHECK loops; no timeout SHALL exist.
REQ-017 When cards_dealt=52, shoe_empty SHALL be 1 and requests SHALL be ignored; no gnt SHALL be issued.
REQ-018 clear_shoe SHALL zero dealt_mask, cards_dealt and both card registers next edge and force IDLE; an in-flight deal SHALL be aborted without gnt, and clear SHALL win over a simultaneous WRITE.
REQ-019 A request dropped mid-deal SHALL NOT abort the deal; the card SHALL still be delivered.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 enable=0 SHALL only block new deals from IDLE; an in-flight deal SHALL complete.

Reset
REQ-022 On reset, the FSM SHALL be IDLE and lfsr SHALL be 6'h2A.
REQ-023 On reset, dealt_mask, cards_dealt, enable, player_card, dealer_card, gnt_player, gnt_dealer, readdata-backing registers and shoe_empty SHALL be 0.
REQ-024 On reset, last-served SHALL be dealer.

Configuration
REQ-025 With DEAL_SCHED_SEED_WR_EN defined, a SEED write while IDLE SHALL load lfsr with writedata[5:0]; a value of 0 SHALL be replaced by 6'h2A; writes while busy SHALL be ignored; SEED SHALL read the current lfsr.
REQ-026 Without DEAL_SCHED_SEED_WR_EN, SEED writes SHALL be ignored and SEED SHALL read 0.

Verification
REQ-027 Reset, CTRL=2, req_player held -> player_card=0x95 (card 21) with gnt_player 4 edges after the sample, then 0xAB (43), then 0x97 (23).
REQ-028 Both requests held from reset -> grants alternate player, dealer, player...; no gnt is issued on consecutive cycles for the same side while both requests are held.
REQ-029 53 deals requested -> 52 distinct cards, cards_dealt=52, shoe_empty=1, 53rd request has no gnt.
REQ-030 clear_shoe written while the FSM is in CHECK -> no gnt, cards_dealt=0, card ports 0, next deal restarts from the current lfsr.
REQ-031 With DEAL_SCHED_SEED_WR_EN, SEED=1 -> first card=2; SEED=0 -> first card=21; SEED write while busy -> ignored.
REQ-032 Reset asserted mid-DRAW -> all outputs 0 asynchronously; lfsr=0x2A after release.

Source files
------------

// File: rtl/deal_scheduler_if.sv
// deal_scheduler_if: Avalon-MM register bus between a host and deal_scheduler.
// The host side uses the master modport, the scheduler uses the slave modport.
interface deal_scheduler_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport slave  (input address, input chipselect, input write_n, input writedata,
                   output readdata);
   modport master (output address, output chipselect, output write_n, output writedata,
                   input readdata);
endinterface

// File: rtl/deal_scheduler.sv
// deal_scheduler: deals cards 1..52 without repetition to a player and a dealer.
// Each request is served by walking a 6-bit maximal-length LFSR until it lands
// on a card that is still in the shoe. Ties alternate between the two sides.
// Optional feature: define DEAL_SCHED_SEED_WR_EN to make the SEED register
// writable (while idle) and readable; without it SEED is inert and reads 0.
module deal_scheduler (
   input  logic                   clk,
   input  logic                   reset,
   deal_scheduler_if.slave        bus,
   input  logic                   req_player,
   input  logic                   req_dealer,
   output logic                   gnt_player,
   output logic                   gnt_dealer,
   output logic [7:0]             player_card,
   output logic [7:0]             dealer_card,
   output logic                   shoe_empty
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAW  = 2'd1,
      ST_CHECK = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   localparam logic [5:0] LFSR_RESET  = 6'h2A;
   localparam logic [5:0] DECK_SIZE   = 6'd52;
   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_SEED   = 2'd2;

   // x^6 + x^5 + 1 Fibonacci step; period 63 over all non-zero states.
   function automatic logic [5:0] lfsr_next(input logic [5:0] cur);
      lfsr_next = {cur[4:0], cur[5] ^ cur[4]};
   endfunction

   state_t      state_q, state_d;
   logic [5:0]  lfsr_q, lfsr_d;
   logic [51:0] dealt_mask_q, dealt_mask_d;
   logic [5:0]  cards_dealt_q, cards_dealt_d;
   logic        enable_q, enable_d;
   logic        winner_dealer_q, winner_dealer_d;  // 1: current deal goes to the dealer
   logic        last_dealer_q, last_dealer_d;      // 1: dealer was served last
   logic [7:0]  player_card_q, player_card_d;
   logic [7:0]  dealer_card_q, dealer_card_d;
   logic        gnt_player_q, gnt_player_d;
   logic        gnt_dealer_q, gnt_dealer_d;
   logic        shoe_empty_q, shoe_empty_d;

   logic        wr_s;
   logic        ctrl_wr_s;
   logic        clear_s;
   logic        seed_wr_s;
   logic        seed_load_s;
   logic [5:0]  seed_value_s;
   logic        start_s;
   logic        busy_s;
   logic [5:0]  card_idx_s;
   logic        card_ok_s;
   logic [31:0] readdata_s;
   logic        unused_wdata_s;

   assign wr_s         = bus.chipselect & ~bus.write_n;
   assign ctrl_wr_s    = wr_s & (bus.address == ADDR_CTRL);
   assign clear_s      = ctrl_wr_s & bus.writedata[0];
   assign seed_wr_s    = wr_s & (bus.address == ADDR_SEED) & (state_q == ST_IDLE);
   assign seed_value_s = (bus.writedata[5:0] == 6'd0) ? LFSR_RESET : bus.writedata[5:0];
`ifdef DEAL_SCHED_SEED_WR_EN
   assign seed_load_s  = seed_wr_s;
`else
   assign seed_load_s  = 1'b0;
`endif
   assign unused_wdata_s = ^{bus.writedata, seed_wr_s};

   assign busy_s     = (state_q != ST_IDLE);
   assign start_s    = (state_q == ST_IDLE) & enable_q & ~shoe_empty_q &
                       (req_player | req_dealer);
   // A candidate is usable only if it names a real card still in the shoe.
   assign card_idx_s = lfsr_q - 6'd1;
   assign card_ok_s  = (lfsr_q != 6'd0) && (lfsr_q <= DECK_SIZE) && !dealt_mask_q[card_idx_s];

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: a shoe clear aborts any deal in flight
   always_comb begin
      state_d = state_q;
      if (clear_s) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_s) begin
                  state_d = ST_DRAW;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_DRAW:  state_d = ST_CHECK;
            ST_CHECK: begin
               if (card_ok_s) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_DRAW;
               end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // FSM outputs and datapath: winner latch, LFSR walk, card delivery, shoe clear
   always_comb begin
      lfsr_d          = lfsr_q;
      dealt_mask_d    = dealt_mask_q;
      cards_dealt_d   = cards_dealt_q;
      winner_dealer_d = winner_dealer_q;
      last_dealer_d   = last_dealer_q;
      player_card_d   = player_card_q;
      dealer_card_d   = dealer_card_q;
      gnt_player_d    = 1'b0;
      gnt_dealer_d    = 1'b0;
      if (ctrl_wr_s) begin
         enable_d = bus.writedata[1];
      end else begin
         enable_d = enable_q;
      end
      if (clear_s) begin
         dealt_mask_d  = 52'd0;
         cards_dealt_d = 6'd0;
         player_card_d = 8'd0;
         dealer_card_d = 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_s) begin
                  // Tie goes to whichever side was not served last.
                  winner_dealer_d = req_dealer & (~req_player | ~last_dealer_q);
               end else begin
                  winner_dealer_d = winner_dealer_q;
               end
               if (seed_load_s) begin
                  lfsr_d = seed_value_s;
               end else begin
                  lfsr_d = lfsr_q;
               end
            end
            ST_DRAW: begin
               lfsr_d = lfsr_next(lfsr_q);
            end
            ST_CHECK: begin
               lfsr_d = lfsr_q;
            end
            ST_WRITE: begin
               dealt_mask_d[card_idx_s] = 1'b1;
               cards_dealt_d            = cards_dealt_q + 6'd1;
               last_dealer_d            = winner_dealer_q;
               if (winner_dealer_q) begin
                  dealer_card_d = {1'b1, 1'b0, lfsr_q};
                  gnt_dealer_d  = 1'b1;
               end else begin
                  player_card_d = {1'b1, 1'b0, lfsr_q};
                  gnt_player_d  = 1'b1;
               end
            end
            default: begin
               lfsr_d = lfsr_q;
            end
         endcase
      end
      shoe_empty_d = (cards_dealt_d == DECK_SIZE);
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q          <= LFSR_RESET;
         dealt_mask_q    <= 52'd0;
         cards_dealt_q   <= 6'd0;
         enable_q        <= 1'b0;
         winner_dealer_q <= 1'b0;
         last_dealer_q   <= 1'b1;
         player_card_q   <= 8'd0;
         dealer_card_q   <= 8'd0;
         gnt_player_q    <= 1'b0;
         gnt_dealer_q    <= 1'b0;
         shoe_empty_q    <= 1'b0;
      end else begin
         lfsr_q          <= lfsr_d;
         dealt_mask_q    <= dealt_mask_d;
         cards_dealt_q   <= cards_dealt_d;
         enable_q        <= enable_d;
         winner_dealer_q <= winner_dealer_d;
         last_dealer_q   <= last_dealer_d;
         player_card_q   <= player_card_d;
         dealer_card_q   <= dealer_card_d;
         gnt_player_q    <= gnt_player_d;
         gnt_dealer_q    <= gnt_dealer_d;
         shoe_empty_q    <= shoe_empty_d;
      end
   end

   // Register read mux, combinational on address
   always_comb begin
      readdata_s = 32'd0;
      case (bus.address)
         ADDR_STATUS: readdata_s = {18'd0, cards_dealt_q, 6'd0, shoe_empty_q, busy_s};
`ifdef DEAL_SCHED_SEED_WR_EN
         ADDR_SEED:   readdata_s = {26'd0, lfsr_q};
`else
         ADDR_SEED:   readdata_s = 32'd0;
`endif
         default:     readdata_s = 32'd0;
      endcase
   end

   assign bus.readdata = readdata_s;
   assign gnt_player   = gnt_player_q;
   assign gnt_dealer   = gnt_dealer_q;
   assign player_card  = player_card_q;
   assign dealer_card  = dealer_card_q;
   assign shoe_empty   = shoe_empty_q;

endmodule

// File: tb/tb_deal_scheduler.sv
// tb_deal_scheduler: table-driven, hand-written and randomized checks of
// deal_scheduler against a transaction-level model of the shoe.
module tb_deal_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_player = 1'b0;
   logic       req_dealer = 1'b0;
   logic       gnt_player, gnt_dealer, shoe_empty;
   logic [7:0] player_card, dealer_card;

   deal_scheduler_if bus_if ();

   deal_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus_if),
      .req_player  (req_player),
      .req_dealer  (req_dealer),
      .gnt_player  (gnt_player),
      .gnt_dealer  (gnt_dealer),
      .player_card (player_card),
      .dealer_card (dealer_card),
      .shoe_empty  (shoe_empty)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- reference model (transaction level) ----------------
   int m_lfsr;
   bit m_dealt [0:63];
   int m_count;
   bit m_last_dealer;
   bit seen [0:63];
   int distinct;

   function automatic int step(input int x);
      return ((x * 2) % 64) + (((x / 32) ^ (x / 16)) % 2);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 64; i++) begin
         m_dealt[i] = 1'b0;
         seen[i] = 1'b0;
      end
      m_count = 0;
      distinct = 0;
   endtask

   task automatic model_reset();
      model_clear();
      m_lfsr = 42;
      m_last_dealer = 1'b1;
   endtask

   task automatic model_deal(input logic p, input logic d, output logic [1:0] es,
                             output logic [7:0] ec, output int el);
      bit win_dealer;
      int x, k;
      win_dealer = (p && d) ? !m_last_dealer : d;
      x = m_lfsr;
      k = 0;
      do begin
         x = step(x);
         k++;
      end while (!(x >= 1 && x <= 52 && !m_dealt[x]) && k < 64);
      m_lfsr = x;
      m_dealt[x] = 1'b1;
      m_count++;
      m_last_dealer = win_dealer;
      es = win_dealer ? 2'b10 : 2'b01;
      ec = 8'h80 | 8'(x);
      el = 2 * k + 2;
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic note_card(input logic [7:0] c);
      int v;
      v = int'(c[5:0]);
      if (v >= 1 && v <= 52 && !seen[v]) begin
         seen[v] = 1'b1;
         distinct++;
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
      bus_if.address    = a;
      bus_if.writedata  = v;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      @(posedge clk); #1;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
      bus_if.address    = a;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b1;
      #1;
      v = bus_if.readdata;
      bus_if.chipselect = 1'b0;
   endtask

   // Waits for a grant; edges_done edges after the sample edge already elapsed.
   task automatic wait_gnt(input int edges_done, output logic [1:0] side,
                           output logic [7:0] card, output int lat);
      side = 2'b00;
      card = 8'h00;
      lat  = 0;
      for (int n = edges_done + 1; n <= 300; n++) begin
         @(posedge clk); #1;
         if (gnt_player || gnt_dealer) begin
            side = {gnt_dealer, gnt_player};
            card = gnt_dealer ? dealer_card : player_card;
            lat  = n + 1;
            break;
         end
      end
      req_player = 1'b0;
      req_dealer = 1'b0;
   endtask

   task automatic do_deal(input logic p, input logic d, input logic drop,
                          output logic [1:0] side, output logic [7:0] card, output int lat);
      req_player = p;
      req_dealer = d;
      @(posedge clk); #1;
      if (drop) begin
         req_player = 1'b0;
         req_dealer = 1'b0;
      end
      wait_gnt(0, side, card, lat);
   endtask

   task automatic compare_deal(input string tag, input logic p, input logic d,
                               input logic [1:0] side, input logic [7:0] card, input int lat);
      logic [1:0] es;
      logic [7:0] ec;
      int el;
      model_deal(p, d, es, ec, el);
      check($sformatf("%s_side", tag), 32'(side), 32'(es));
      check($sformatf("%s_card", tag), 32'(card), 32'(ec));
      check($sformatf("%s_lat", tag), lat, el);
      note_card(card);
   endtask

   task automatic run_deal(input string tag, input logic p, input logic d, input logic drop,
                           output logic [7:0] card);
      logic [1:0] side;
      int lat;
      do_deal(p, d, drop, side, card, lat);
      compare_deal(tag, p, d, side, card, lat);
   endtask

   typedef struct {
      logic       p;
      logic       d;
      logic [1:0] side;
      logic [7:0] card;
      int         lat;
   } vec_t;

   vec_t tbl [7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [7:0]  card;
      logic [1:0]  side, prev;
      int          lat, got;
      bit          seen_gnt, seen_busy;

      tbl[0] = '{1'b1, 1'b0, 2'b01, 8'h95, 4};
      tbl[1] = '{1'b1, 1'b0, 2'b01, 8'hAB, 4};
      tbl[2] = '{1'b1, 1'b0, 2'b01, 8'h97, 4};
      tbl[3] = '{1'b1, 1'b1, 2'b10, 8'hAF, 4};
      tbl[4] = '{1'b1, 1'b1, 2'b01, 8'h9F, 4};
      tbl[5] = '{1'b0, 1'b1, 2'b10, 8'hB0, 12};
      tbl[6] = '{1'b1, 1'b0, 2'b01, 8'hA0, 4};

      bus_if.address    = 2'd0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.writedata  = 32'd0;
      model_reset();

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      check("reset_outputs", {14'd0, gnt_player, gnt_dealer, player_card, dealer_card, shoe_empty}, 32'd0);
      bus_read(2'd1, rd);
      check("reset_status", rd, 32'd0);
      bus_read(2'd2, rd);
`ifdef DEAL_SCHED_SEED_WR_EN
      check("reset_seed", rd, 32'h2A);
`else
      check("reset_seed", rd, 32'd0);
`endif
      reset = 1'b0;
      @(posedge clk); #1;

      // Enable is still off: a request must not be served
      req_player = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      req_player = 1'b0;
      check("disabled_no_gnt", player_card, 8'h00);

      bus_write(2'd0, 32'd2);

      // Table-driven deals from the reset seed
      for (int i = 0; i < 7; i++) begin
         do_deal(tbl[i].p, tbl[i].d, 1'b0, side, card, lat);
         check($sformatf("tbl%0d_side", i), 32'(side), 32'(tbl[i].side));
         check($sformatf("tbl%0d_card", i), 32'(card), 32'(tbl[i].card));
         check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
         compare_deal($sformatf("tbl%0d_model", i), tbl[i].p, tbl[i].d, side, card, lat);
      end
      bus_read(2'd1, rd);
      check("status_after_table", rd, 32'h0000_0700);

      // Clear while the deal sits in CHECK
      req_player = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus_read(2'd1, rd);
      check("busy_in_check", rd[0], 1'b1);
      req_player = 1'b0;
      bus_write(2'd0, 32'd3);
      m_lfsr = step(m_lfsr);
      model_clear();
      check("clear_cards", {16'd0, player_card, dealer_card}, 32'd0);
      bus_read(2'd1, rd);
      check("clear_status", rd, 32'd0);
      seen_gnt = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (gnt_player || gnt_dealer) seen_gnt = 1'b1;
      end
      check("clear_no_gnt", seen_gnt, 1'b0);
      run_deal("after_clear", 1'b1, 1'b0, 1'b0, card);
      check("after_clear_const", card, 8'h82);

      // Randomized deals, requests sometimes dropped right after the sample
      for (int i = 0; i < 30; i++) begin
         int pat;
         pat = $urandom_range(1, 3);
         run_deal($sformatf("rnd%0d", i), pat[0], pat[1], 1'($urandom_range(0, 1)), card);
      end

      // Both requests held: grants must alternate sides
      req_player = 1'b1;
      req_dealer = 1'b1;
      prev = 2'b00;
      got = 0;
      for (int n = 0; n < 400 && got < 6; n++) begin
         @(posedge clk); #1;
         if (gnt_player || gnt_dealer) begin
            logic [1:0] es;
            logic [7:0] ec;
            int el;
            side = {gnt_dealer, gnt_player};
            card = gnt_dealer ? dealer_card : player_card;
            model_deal(1'b1, 1'b1, es, ec, el);
            check($sformatf("alt%0d_side", got), 32'(side), 32'(es));
            check($sformatf("alt%0d_card", got), 32'(card), 32'(ec));
            if (got > 0) check($sformatf("alt%0d_toggle", got), 32'(side != prev), 32'd1);
            note_card(card);
            prev = side;
            got++;
         end
      end
      req_player = 1'b0;
      req_dealer = 1'b0;
      check("alt_count", got, 6);

      // Drain the shoe
      while (m_count < 52) begin
         run_deal($sformatf("drain%0d", m_count), 1'b1, 1'b0, 1'b0, card);
      end
      check("distinct_cards", distinct, 52);
      check("shoe_empty_port", shoe_empty, 1'b1);
      bus_read(2'd1, rd);
      check("status_full", rd, 32'h0000_3402);
      req_player = 1'b1;
      seen_gnt  = 1'b0;
      seen_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (gnt_player || gnt_dealer) seen_gnt = 1'b1;
         bus_read(2'd1, rd);
         if (rd[0]) seen_busy = 1'b1;
      end
      req_player = 1'b0;
      check("empty_no_gnt", seen_gnt, 1'b0);
      check("empty_not_busy", seen_busy, 1'b0);

      // Disable mid-deal: the deal in flight still completes
      bus_write(2'd0, 32'd3);
      model_clear();
      check("refill_empty_flag", shoe_empty, 1'b0);
      req_player = 1'b1;
      @(posedge clk); #1;
      req_player = 1'b0;
      bus_write(2'd0, 32'd0);
      wait_gnt(1, side, card, lat);
      compare_deal("disable_inflight", 1'b1, 1'b0, side, card, lat);
      req_dealer = 1'b1;
      seen_gnt = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (gnt_player || gnt_dealer) seen_gnt = 1'b1;
      end
      req_dealer = 1'b0;
      check("disabled_blocks", seen_gnt, 1'b0);

      // SEED register
      bus_write(2'd0, 32'd3);
      model_clear();
      bus_write(2'd2, 32'd1);
`ifdef DEAL_SCHED_SEED_WR_EN
      m_lfsr = 1;
      bus_read(2'd2, rd);
      check("seed1_read", rd, 32'd1);
      run_deal("seed1", 1'b1, 1'b0, 1'b0, card);
      check("seed1_const", card, 8'h82);
      bus_write(2'd0, 32'd3);
      model_clear();
      bus_write(2'd2, 32'd0);
      m_lfsr = 42;
      bus_read(2'd2, rd);
      check("seed0_read", rd, 32'h2A);
      run_deal("seed0", 1'b1, 1'b0, 1'b0, card);
      check("seed0_const", card, 8'h95);
`else
      bus_read(2'd2, rd);
      check("seed_inert_read", rd, 32'd0);
      run_deal("seed_inert", 1'b1, 1'b0, 1'b0, card);
`endif
      req_player = 1'b1;
      @(posedge clk); #1;
      req_player = 1'b0;
      bus_write(2'd2, 32'd5);
      wait_gnt(1, side, card, lat);
      compare_deal("seed_busy", 1'b1, 1'b0, side, card, lat);
      bus_read(2'd2, rd);
`ifdef DEAL_SCHED_SEED_WR_EN
      check("seed_busy_read", rd, 32'(m_lfsr));
`else
      check("seed_busy_read", rd, 32'd0);
`endif

      // Asynchronous reset in the middle of DRAW
      req_player = 1'b1;
      @(posedge clk); #1;
      #2 reset = 1'b1;
      #1;
      check("async_reset_outputs", {14'd0, gnt_player, gnt_dealer, player_card, dealer_card, shoe_empty}, 32'd0);
      bus_read(2'd1, rd);
      check("async_reset_status", rd, 32'd0);
      req_player = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
`ifdef DEAL_SCHED_SEED_WR_EN
      bus_read(2'd2, rd);
      check("post_reset_seed", rd, 32'h2A);
`endif
      bus_write(2'd0, 32'd2);
      run_deal("post_reset", 1'b1, 1'b0, 1'b0, card);
      check("post_reset_const", card, 8'h95);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
